sync_coupled_cell: RTL and testbench
====================================

# sync_coupled_cell

Clocked, parametrised coupled-oscillator cell for the NxN Ising array. Each instance forwards a source-ring bit (`sin`→`sout`) and a destination-ring bit (`din`→`dout`). Each transition is delayed by a whole number of clock cycles. The delay is chosen from a signed coupling weight and from whether the two rings agree. The weight range is configurable and is loaded through a valid/ready handshake. Weight changes apply only while both delay paths are idle, so an in-flight edge is never retimed.

## Interface
- `NUM_WEIGHT`, default 2: coupling range is −NUM_WEIGHT…+NUM_WEIGHT, encoded offset-binary (code = coupling + NUM_WEIGHT).
- `WEIGHT_WIDTH`, default `$clog2(2*NUM_WEIGHT+1)`: width of the weight code.
- `DELAY_STEP`, default 2: extra cycles added per unit of slow-down.
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `weight`, input, WEIGHT_WIDTH: new weight code.
- `weight_valid`, input, 1: a new weight is offered.
- `weight_ready`, output, 1: high when both paths are IDLE, so the weight can be accepted.
- `weight_err`, output, 1: registered. High while the latched code is greater than 2*NUM_WEIGHT.
- `sin`, input, 1: source-ring input, synchronous to `clk`.
- `din`, input, 1: destination-ring input, synchronous to `clk`.
- `sout`, output, 1: registered source-ring output.
- `dout`, output, 1: registered destination-ring output.
- `s_busy`, output, 1: source path is PENDING.
- `d_busy`, output, 1: destination path is PENDING.

## Operation
- **Reset values.** Weight register = NUM_WEIGHT (zero coupling). `sout`=`dout`=0. Both paths IDLE. `weight_ready`=1, `weight_err`=0, `s_busy`=`d_busy`=0.
- **Weight decode.** c = code − NUM_WEIGHT. A code greater than 2*NUM_WEIGHT decodes as c=0 and sets `weight_err`.
- **Weight accept.** The weight is accepted on a clock edge where `weight_valid` && `weight_ready`. The new value takes effect from the following edge.
- **Mismatch terms.** mismatch_s = `sin`^`dout`; mismatch_d = `din`^`sout`. Both are evaluated at capture.
- **Slow-down amount.** slow = |c| when (c>0 && mismatch) or (c<0 && !mismatch); otherwise 0.
- **Path FSM.** Each path is an identical two-state machine: IDLE and PENDING. Described here for the source path:
  - IDLE, `sin`==`sout`: stay IDLE.
  - IDLE, `sin`!=`sout`, slow=0: `sout` <= `sin` on this edge. Stay IDLE.
  - IDLE, `sin`!=`sout`, slow>0: capture target=`sin`. Load cnt = slow*DELAY_STEP − 1. Go to PENDING.
  - PENDING, `sin`!=target: cancel. Go to IDLE, `sout` unchanged. The short pulse is swallowed and no glitch reaches `sout`.
  - PENDING, cnt==0: `sout` <= target. Go to IDLE.
  - PENDING otherwise: cnt <= cnt−1.
- **Counter width.** The counter is `$clog2(NUM_WEIGHT*DELAY_STEP+1)` bits and never wraps.

## Timing
- **Base latency.** `sin` is first sampled different from `sout` at edge N. With slow=0, `sout` updates at edge N. With slow=k, `sout` updates at edge N + k*DELAY_STEP.
- **Capture uses the old weight.** If a weight is accepted on the same edge as a capture, the capture uses the old weight.
- **weight_ready.** Combinational from the registered path states only.
- **Re-capture after cancel.** A cancelled path may re-capture on the edge after cancellation.
- **Simultaneous events.** Source and destination capture independently. Each uses the opposite output's registered value as it stands at that edge.
- **Reset mid-operation.** `rstn` asserted at any time forces all reset values immediately. Pending transitions are discarded.

## Structure
- **Shared package `coupled_pkg`:**
  - path state enum (IDLE, PENDING);
  - a `decode_weight` function returning {sign, magnitude, err};
  - a `slow_amount` function.
- **Sub-module `coupled_delay_path`:** one path FSM plus counter. It takes in, target-out, mismatch, sign and magnitude. It is instantiated twice.
- **Top level:** holds the weight register, the handshake and the error flag.

## Test plan
All scenarios use NUM_WEIGHT=2 and DELAY_STEP=2.
1. **Reset.** Assert `rstn` low → `sout`=`dout`=0, `weight_ready`=1, `weight_err`=0. Weight reads as zero: a `sin` 0→1 at edge N gives `sout`=1 at edge N.
2. **Positive coupling, mismatch and match.** Load code 4 (+2), `dout`=0, `sin` 0→1 sampled at edge N → `sout` rises at N+4, `s_busy` high for 4 cycles. Repeat with `dout`=1 → `sout` rises at edge N.
3. **Negative coupling.** Code 0 (−2), match → delay 4. Code 1 (−1), match → delay 2. Code 1, mismatch → delay 0.
4. **Cancel.** Code 4, mismatch, `sin` high for 2 cycles only → `sout` never changes. Path returns IDLE on the revert edge.
5. **Handshake while busy.** Hold `weight_valid` with code 3 during a PENDING period → `weight_ready`=0, weight not taken. It is accepted on the first edge with both paths IDLE, and the next capture uses +1.
6. **Bad code and mid-flight reset.** Load code 7 → `weight_err`=1, behaves as zero coupling. Pull `rstn` low during PENDING → outputs 0 immediately, both busy flags 0.

Source files
------------

// File: rtl/coupled_pkg.sv
// rtl/coupled_pkg.sv - shared types and weight helpers for the coupled oscillator cell
// Contents:
//   path_state_e  : delay path state (IDLE / PENDING)
//   weight_dec_t  : decoded weight {sign, magnitude, err}
//   decode_weight : offset-binary code -> signed coupling; out-of-range codes decode as zero
//   slow_amount   : number of slow-down units for one capture
package coupled_pkg;

    localparam int CODE_W = 8;
    localparam int MAG_W  = 8;

    typedef enum logic {
        PATH_IDLE    = 1'b0,
        PATH_PENDING = 1'b1
    } path_state_e;

    typedef struct packed {
        logic             sign;  // 1 = negative coupling
        logic [MAG_W-1:0] mag;
        logic             err;
    } weight_dec_t;

    function automatic weight_dec_t decode_weight(input logic [CODE_W-1:0] code,
                                                  input logic [MAG_W-1:0]  num_weight);
        weight_dec_t     dec;
        logic [CODE_W:0] max_code;
        max_code = {1'b0, num_weight} << 1;
        dec      = '0;
        if ({1'b0, code} > max_code) begin
            dec.err = 1'b1;
        end else if (code >= num_weight) begin
            dec.mag = code - num_weight;
        end else begin
            dec.sign = 1'b1;
            dec.mag  = num_weight - code;
        end
        return dec;
    endfunction

    // Positive coupling slows disagreeing rings, negative coupling slows agreeing ones.
    function automatic logic [MAG_W-1:0] slow_amount(input logic             sign,
                                                     input logic [MAG_W-1:0] mag,
                                                     input logic             mismatch);
        return (sign ^ mismatch) ? mag : '0;
    endfunction

endpackage

// File: rtl/coupled_delay_path.sv
// rtl/coupled_delay_path.sv - one ring path: edge capture, programmable delay, cancel
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   in_i       : ring input bit
//   mismatch_i : input disagrees with the opposite ring's registered output
//   sign_i     : coupling sign (1 = negative)
//   mag_i      : coupling magnitude
//   out_o      : registered ring output
//   busy_o     : path is PENDING
module coupled_delay_path
    import coupled_pkg::*;
#(
    parameter int DELAY_STEP = 2,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_i,
    input  logic             mismatch_i,
    input  logic             sign_i,
    input  logic [MAG_W-1:0] mag_i,
    output logic             out_o,
    output logic             busy_o
);

    path_state_e      state_q;
    logic             out_q;
    logic             target_q;
    logic [CNT_W-1:0] cnt_q;

    logic [MAG_W-1:0] slow;
    logic [CNT_W-1:0] load_val;

    assign slow = slow_amount(sign_i, mag_i, mismatch_i);
    // Capture edge itself counts as the first delay cycle, hence the -1.
    assign load_val = CNT_W'(int'(slow) * DELAY_STEP - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= PATH_IDLE;
            out_q    <= 1'b0;
            target_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                PATH_IDLE: begin
                    if (in_i != out_q) begin
                        if (slow == '0) begin
                            out_q <= in_i;
                        end else begin
                            target_q <= in_i;
                            cnt_q    <= load_val;
                            state_q  <= PATH_PENDING;
                        end
                    end
                end
                PATH_PENDING: begin
                    // Input reverted before the delay expired: swallow the pulse.
                    if (in_i != target_q) begin
                        state_q <= PATH_IDLE;
                    end else if (cnt_q == '0) begin
                        out_q   <= target_q;
                        state_q <= PATH_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_o  = out_q;
    assign busy_o = (state_q == PATH_PENDING);

endmodule

// File: rtl/sync_coupled_cell.sv
// rtl/sync_coupled_cell.sv - coupled oscillator cell: weight register, handshake, two delay paths
// Ports:
//   clk, rstn                  : clock, asynchronous active-low reset
//   weight, weight_valid       : offset-binary weight code offer
//   weight_ready               : both paths idle, offer can be taken
//   weight_err                 : latched code is out of range (treated as zero coupling)
//   sin -> sout, din -> dout   : source and destination ring bits
//   s_busy, d_busy             : path PENDING flags
module sync_coupled_cell
    import coupled_pkg::*;
#(
    parameter int NUM_WEIGHT   = 2,
    parameter int WEIGHT_WIDTH = $clog2(2 * NUM_WEIGHT + 1),
    parameter int DELAY_STEP   = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [WEIGHT_WIDTH-1:0] weight,
    input  logic                    weight_valid,
    output logic                    weight_ready,
    output logic                    weight_err,
    input  logic                    sin,
    input  logic                    din,
    output logic                    sout,
    output logic                    dout,
    output logic                    s_busy,
    output logic                    d_busy
);

    localparam int CNT_W = $clog2(NUM_WEIGHT * DELAY_STEP + 1);

    logic [WEIGHT_WIDTH-1:0] weight_q;
    logic                    weight_err_q;
    weight_dec_t             cur_dec;
    weight_dec_t             new_dec;
    logic                    unused_dec;

    assign cur_dec    = decode_weight(CODE_W'(weight_q), MAG_W'(NUM_WEIGHT));
    assign new_dec    = decode_weight(CODE_W'(weight), MAG_W'(NUM_WEIGHT));
    assign unused_dec = ^{cur_dec.err, new_dec.sign, new_dec.mag};

    // Only while no edge is in flight, so a pending delay is never retimed.
    assign weight_ready = !s_busy && !d_busy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weight_q     <= WEIGHT_WIDTH'(NUM_WEIGHT);
            weight_err_q <= 1'b0;
        end else if (weight_valid && weight_ready) begin
            weight_q     <= weight;
            weight_err_q <= new_dec.err;
        end
    end

    assign weight_err = weight_err_q;

    coupled_delay_path #(
        .DELAY_STEP (DELAY_STEP),
        .CNT_W      (CNT_W)
    ) u_s_path (
        .clk        (clk),
        .rstn       (rstn),
        .in_i       (sin),
        .mismatch_i (sin ^ dout),
        .sign_i     (cur_dec.sign),
        .mag_i      (cur_dec.mag),
        .out_o      (sout),
        .busy_o     (s_busy)
    );

    coupled_delay_path #(
        .DELAY_STEP (DELAY_STEP),
        .CNT_W      (CNT_W)
    ) u_d_path (
        .clk        (clk),
        .rstn       (rstn),
        .in_i       (din),
        .mismatch_i (din ^ sout),
        .sign_i     (cur_dec.sign),
        .mag_i      (cur_dec.mag),
        .out_o      (dout),
        .busy_o     (d_busy)
    );

endmodule

// File: tb/tb_sync_coupled_cell.sv
// tb/tb_sync_coupled_cell.sv - scoreboard bench for sync_coupled_cell
module tb_sync_coupled_cell;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] weight = 3'd0;
    logic       weight_valid = 1'b0;
    logic       weight_ready;
    logic       weight_err;
    logic       sin = 1'b0;
    logic       din = 1'b0;
    logic       sout;
    logic       dout;
    logic       s_busy;
    logic       d_busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_busy = 0;
    int exp_q[$];

    sync_coupled_cell #(
        .NUM_WEIGHT   (2),
        .WEIGHT_WIDTH (3),
        .DELAY_STEP   (2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .weight       (weight),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .weight_err   (weight_err),
        .sin          (sin),
        .din          (din),
        .sout         (sout),
        .dout         (dout),
        .s_busy       (s_busy),
        .d_busy       (d_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one ring edge and score the latency (edges from first sample to output update).
    task automatic drive_edge(input bit path, input bit val, input int exp_delay, input string tag);
        int n;
        int got;
        int busy_cnt;
        @(negedge clk);
        if (path) din = val; else sin = val;
        n = cyc + 1;
        exp_q.push_back(exp_delay);
        got = -1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((path ? dout : sout) == val) begin
                got = cyc - n;
                break;
            end
            if (path ? d_busy : s_busy) busy_cnt++;
        end
        check_eq(tag, got, exp_q.pop_front());
        last_busy = busy_cnt;
    endtask

    task automatic load_weight(input logic [2:0] code, input string tag);
        @(negedge clk);
        weight = code;
        weight_valid = 1'b1;
        for (int i = 0; i < 50 && !weight_ready; i++) @(negedge clk);
        check_eq(tag, int'(weight_ready), 1);
        @(negedge clk);
        weight_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got;
        int glitch;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_sout", int'(sout), 0);
        check_eq("rst_dout", int'(dout), 0);
        check_eq("rst_ready", int'(weight_ready), 1);
        check_eq("rst_err", int'(weight_err), 0);
        check_eq("rst_busy", int'({s_busy, d_busy}), 0);
        rstn = 1'b1;
        drive_edge(0, 1'b1, 0, "rst_zero_rise");
        drive_edge(0, 1'b0, 0, "rst_zero_fall");

        // Positive coupling +2
        load_weight(3'd4, "ld_p2");
        drive_edge(0, 1'b1, 4, "p2_mismatch_rise");
        check_eq("p2_busy_cycles", last_busy, 4);
        drive_edge(1, 1'b1, 0, "p2_d_match_rise");
        drive_edge(0, 1'b0, 4, "p2_mismatch_fall");
        drive_edge(0, 1'b1, 0, "p2_match_rise");

        // Negative coupling
        load_weight(3'd0, "ld_m2");
        drive_edge(1, 1'b0, 0, "m2_d_mismatch_fall");
        drive_edge(0, 1'b0, 4, "m2_match_fall");
        load_weight(3'd1, "ld_m1");
        drive_edge(0, 1'b1, 0, "m1_mismatch_rise");
        drive_edge(0, 1'b0, 2, "m1_match_fall");

        // Cancel: 2-cycle pulse under +2 mismatch
        load_weight(3'd4, "ld_cancel");
        @(negedge clk); sin = 1'b1;
        @(negedge clk); check_eq("cancel_busy", int'(s_busy), 1);
        @(negedge clk); sin = 1'b0;
        @(negedge clk); check_eq("cancel_idle", int'(s_busy), 0);
        glitch = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sout) glitch++;
        end
        check_eq("cancel_no_glitch", glitch, 0);

        // Handshake while busy
        @(negedge clk);
        sin = 1'b1;
        n = cyc + 1;
        exp_q.push_back(4);
        @(negedge clk);
        weight = 3'd3;
        weight_valid = 1'b1;
        check_eq("hs_ready_busy", int'(weight_ready), 0);
        got = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sout) begin
                got = cyc - n;
                break;
            end
            if (weight_ready) check_eq("hs_ready_early", 1, 0);
        end
        check_eq("hs_old_delay", got, exp_q.pop_front());
        check_eq("hs_ready_idle", int'(weight_ready), 1);
        @(negedge clk);
        weight_valid = 1'b0;
        drive_edge(1, 1'b1, 0, "hs_d_rise");
        drive_edge(0, 1'b0, 2, "hs_new_p1");

        // Bad code, then reset mid-flight
        load_weight(3'd7, "ld_bad");
        check_eq("bad_err", int'(weight_err), 1);
        drive_edge(0, 1'b1, 0, "bad_zero_match");
        drive_edge(0, 1'b0, 0, "bad_zero_mismatch");
        load_weight(3'd4, "ld_p2_again");
        check_eq("err_cleared", int'(weight_err), 0);
        drive_edge(0, 1'b1, 0, "p2_match_rise2");
        @(negedge clk); din = 1'b0;
        @(negedge clk);
        check_eq("mid_d_busy", int'(d_busy), 1);
        check_eq("mid_outs", int'({sout, dout}), 3);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_outs", int'({sout, dout}), 0);
        check_eq("arst_busy", int'({s_busy, d_busy}), 0);
        check_eq("arst_ready", int'(weight_ready), 1);
        check_eq("arst_err", int'(weight_err), 0);
        @(negedge clk);
        sin = 1'b0;
        din = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        drive_edge(0, 1'b1, 0, "arst_weight_zero");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
